ahb3lite_decoder: RTL

Single-master AHB3-lite address decoder and response multiplexer. It generates one-hot HSEL for up to NSLAVES address-mapped slaves, plus a default-slave select for unmapped addresses. It tracks the data phase in a registered select and returns the selected slave's HREADYOUT/HRESP/HRDATA to the master. It sits between the master (or a master-side arbiter) and the slave fabric, and directly feeds ahb3lite_default_slave.

---
 rtl/ahb3lite_decoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/ahb3lite_decoder.sv
// ahb3lite_decoder
// Single-master AHB3-lite address decoder and response multiplexer.
// Decodes HADDR into one-hot slave selects (lowest index wins on overlap),
// with a default-slave select for unmapped addresses. A registered
// data-phase select steers the selected slave's ready/response/data back
// to the master.
// Optional feature macro: AHB3LITE_DECODER_TRACE_EN adds ERR_ADDR/ERR_CNT,
// which record the address and count of unmapped NONSEQ/SEQ transfers.
module ahb3lite_decoder #(
  parameter int                    NSLAVES    = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = '1
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [31:0]             HRDATA,
  output logic [NSLAVES-1:0]      HSEL_S,
  input  logic [NSLAVES-1:0]      HREADYOUT_S,
  input  logic [NSLAVES-1:0]      HRESP_S,
  input  logic [NSLAVES*32-1:0]   HRDATA_S,
  output logic                    HSEL_DEF,
  input  logic                    HREADYOUT_DEF,
  input  logic                    HRESP_DEF,
  input  logic [31:0]             HRDATA_DEF
`ifdef AHB3LITE_DECODER_TRACE_EN
  ,
  output logic [31:0]             ERR_ADDR,
  output logic [15:0]             ERR_CNT
`endif
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Data-phase target: one-hot slave vector plus default flag; all-zero means NONE.
  logic [NSLAVES-1:0] dsel_s_p0;
  logic               dsel_def_p0;
  logic               dec_hit;

  // Address decode: combinational from HADDR only, lowest matching index wins.
  always_comb begin
    HSEL_S  = '0;
    dec_hit = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (!dec_hit &&
          ((HADDR & SLAVE_MASK[32*i +: 32]) ==
           (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]))) begin
        HSEL_S[i] = 1'b1;
        dec_hit   = 1'b1;
      end
    end
    HSEL_DEF = ~dec_hit;
  end

  // Data-phase select: sample the decoded target when the bus is ready, hold during waits.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      dsel_s_p0   <= '0;
      dsel_def_p0 <= 1'b0;
    end else if (HREADY) begin
      if (HTRANS == HTRANS_IDLE) begin
        dsel_s_p0   <= '0;
        dsel_def_p0 <= 1'b0;
      end else begin
        dsel_s_p0   <= HSEL_S;
        dsel_def_p0 <= HSEL_DEF;
      end
    end
  end

  // Response mux: NONE returns an idle OKAY; otherwise pass the selected responder through.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (dsel_def_p0) begin
      HREADY = HREADYOUT_DEF;
      HRESP  = HRESP_DEF;
      HRDATA = HRDATA_DEF;
    end
    for (int i = 0; i < NSLAVES; i++) begin
      if (dsel_s_p0[i]) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[32*i +: 32];
      end
    end
  end

`ifdef AHB3LITE_DECODER_TRACE_EN
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Error trace: capture address and count of active transfers that hit no slave.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ERR_ADDR <= '0;
      ERR_CNT  <= '0;
    end else if (HREADY && !dec_hit &&
                 ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ))) begin
      ERR_ADDR <= HADDR;
      ERR_CNT  <= sat_inc16(ERR_CNT);
    end
  end
`endif

endmodule
